aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
- Host-programmable sequencer for an iterative single-round AES datapath.
- Captures a 128-bit key and a 128-bit block through a word-addressed register bus.
- On start, loads the round core, runs the decrypt key-expansion pass when needed, then steps rounds 0..NR with a req/ack handshake per step.
- Captures the 128-bit result, raises sticky done and an optional interrupt. Sits between the bus slave fabric and the AES round core.

Parameters:
- NR, 10: number of AES rounds. The core is stepped NR+1 times per block; step 0 is the initial AddRoundKey.
- RW, 4: width of core_round; must satisfy 2^RW > NR.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- write  in  1  bus write strobe
- chipselect  in  1  bus select
- address  in  4  word address
- writedata  in  32  bus write data
- readdata  out  32  registered bus read data
- irq  out  1  level interrupt = done & irq_en
- core_load  out  1  one-cycle pulse: core latches core_key/core_block/core_mode
- core_mode  out  1  0 = encrypt, 1 = decrypt
- core_key  out  128  {KEY3,KEY2,KEY1,KEY0}
- core_block  out  128  {DATA3,DATA2,DATA1,DATA0}
- core_kexp  out  1  held high during the decrypt key-expansion phase
- core_req  out  1  step request, held until ack
- core_round  out  RW  current step index
- core_last  out  1  core_req & (core_round == NR) & ~core_kexp
- core_ack  in  1  step complete; valid only while core_req = 1
- core_result  in  128  core output, valid on the ack of the last round

Behaviour:
- Register map:
  - 0 CTRL: write bit0 = start (self-clearing), bit1 = mode, bit2 = irq_en; read {29'b0, irq_en, mode, busy}.
  - 1 STATUS: read {30'b0, done, busy}; writing 1 to bit1 clears done.
  - 2-5 KEY0-3: read/write.
  - 6-9 DATA0-3: read/write.
  - 10-13 RES0-3: read-only.
  - 14-15: read 0, writes ignored.
- readdata is registered and updates every cycle from the current address. Read latency is 1 cycle and is independent of chipselect.
- While busy:
  - Writes to KEY, DATA and CTRL.mode are ignored, and start is ignored.
  - CTRL.irq_en and STATUS done-clear still take effect.
- Reset (reset = 0 on a clock edge): state = IDLE; all registers, readdata, irq, core_* outputs, round counter, done and irq_en go to 0. Reset mid-operation aborts immediately and no result is captured. Reset dominates all simultaneous events.
- FSM:
  - IDLE: busy = 0. A write to CTRL with bit0 = 1 latches mode and sets busy on the same edge, then goes to LOAD. The same start write also clears done.
  - LOAD (1 cycle): core_load = 1. Next state is KEYEXP if mode = 1, otherwise ROUND. Round counter = 0.
  - KEYEXP:
    - core_kexp = 1, core_req = 1, core_round = counter.
    - On ack: if counter == NR-1, set counter = 0 and go to ROUND; otherwise increment counter.
    - NR acks in total.
  - ROUND:
    - core_req = 1, core_round = counter.
    - On ack: if counter == NR, latch core_result into RES0-3 (RES0 = bits 31:0) and go to DONE; otherwise increment counter.
  - DONE (1 cycle): set done, clear busy, go to IDLE. core_req = 0.
- core_req rises on the cycle after LOAD and stays high across consecutive steps. An ack in cycle t advances core_round at t+1.
- core_ack while core_req = 0 is ignored.
- Counter never exceeds NR and does not wrap.
- Minimum latency, encrypt with ack tied high: start write at edge T; LOAD during T..T+1; 11 ROUND cycles; DONE; busy = 0 and done = 1 visible at T+13.
- Decrypt with ack tied high adds NR cycles.

Test Plan:
- Reset: drive reset = 0 for 2 cycles mid-ROUND (counter = 5) -> busy = 0, core_req = 0, irq = 0, RES unchanged at 0, state IDLE; a new start runs from step 0.
- FIPS-197 encrypt: key 000102..0f, data 00112233..eeff, behavioural core model, ack tied high -> exactly one core_load pulse, 11 acks with core_round 0..10, core_last only at 10; RES = 69c4e0d8 6a7b0430 d8cdb780 70b4c55a; done at T+13.
- Decrypt, same key with data 69c4..c55a, ack delayed 3 cycles per step -> 10 kexp steps (core_kexp high, rounds 0..9), then 11 round steps; RES = 00112233..eeff; core_req stays high while waiting.
- Busy protection: during a run, write KEY0 = ffffffff, CTRL = 3, and read STATUS -> KEY0 unchanged, no restart, read returns busy = 1; after done, KEY0 is writable.
- Interrupt: irq_en = 1, run to completion -> irq = 1 until a STATUS write of 2 clears done (irq = 0 the next cycle); a run with irq_en = 0 leaves irq = 0 with done = 1.
- Spurious ack: pulse core_ack in IDLE and during LOAD -> counter stays 0, no state change; address 14 reads 0.

Source files
------------

// File: rtl/aes_round_sched.sv
// Host-programmable sequencer for an iterative single-round AES core.
// Bus side: word-addressed register file (CTRL, STATUS, KEY0-3, DATA0-3, RES0-3)
//   with a registered, 1-cycle-latency readdata and a level irq = done & irq_en.
// Core side: core_load pulse, optional decrypt key-expansion pass (core_kexp),
//   then NR+1 round steps, each a core_req/core_ack handshake; the result is
//   captured on the ack of the last round.
module aes_round_sched #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write,
  input  logic          chipselect,
  input  logic [3:0]    address,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          irq,
  output logic          core_load,
  output logic          core_mode,
  output logic [127:0]  core_key,
  output logic [127:0]  core_block,
  output logic          core_kexp,
  output logic          core_req,
  output logic [RW-1:0] core_round,
  output logic          core_last,
  input  logic          core_ack,
  input  logic [127:0]  core_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KEYEXP,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [RW-1:0] CNT_LAST  = RW'(NR);
  localparam logic [RW-1:0] CNT_KLAST = RW'(NR - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] key_r  [4];
  logic [31:0] data_r [4];
  logic [31:0] res_r  [4];
  logic        mode;
  logic        irq_en;
  logic        done;
  logic [RW-1:0] cnt;
  logic        busy;
  logic        wr;
  logic        start;

  assign busy  = (state != S_IDLE);
  assign wr    = write & chipselect;
  assign start = wr && (address == 4'd0) && writedata[0] && (state == S_IDLE);

  assign irq        = done & irq_en;
  assign core_mode  = mode;
  assign core_key   = {key_r[3], key_r[2], key_r[1], key_r[0]};
  assign core_block = {data_r[3], data_r[2], data_r[1], data_r[0]};
  assign core_round = cnt;
  assign core_last  = core_req & (cnt == CNT_LAST) & ~core_kexp;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    core_load = 1'b0;
    core_kexp = 1'b0;
    core_req  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        state_nxt = mode ? S_KEYEXP : S_ROUND;
      end
      S_KEYEXP: begin
        core_kexp = 1'b1;
        core_req  = 1'b1;
        if (core_ack && cnt == CNT_KLAST) state_nxt = S_ROUND;
      end
      S_ROUND: begin
        core_req = 1'b1;
        if (core_ack && cnt == CNT_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        key_r[i]  <= '0;
        data_r[i] <= '0;
        res_r[i]  <= '0;
      end
      mode     <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      readdata <= '0;
    end else begin
      if (wr) begin
        if (address == 4'd0) begin
          irq_en <= writedata[2];
          if (!busy) mode <= writedata[1];
          if (start) done <= 1'b0;
        end else if (address == 4'd1) begin
          if (writedata[1]) done <= 1'b0;
        end else if (address >= 4'd2 && address <= 4'd5) begin
          if (!busy) key_r[2'(address - 4'd2)] <= writedata;
        end else if (address >= 4'd6 && address <= 4'd9) begin
          if (!busy) data_r[2'(address - 4'd6)] <= writedata;
        end
      end

      case (state)
        S_LOAD: cnt <= '0;
        S_KEYEXP: begin
          if (core_ack) cnt <= (cnt == CNT_KLAST) ? '0 : cnt + RW'(1);
        end
        S_ROUND: begin
          if (core_ack) begin
            if (cnt == CNT_LAST) begin
              for (int unsigned i = 0; i < 4; i++) res_r[i] <= core_result[32*i +: 32];
            end else begin
              cnt <= cnt + RW'(1);
            end
          end
        end
        // Placed after the bus write so a same-cycle done-clear loses to completion.
        S_DONE: done <= 1'b1;
        default: ;
      endcase

      case (address)
        4'd0:                      readdata <= {29'b0, irq_en, mode, busy};
        4'd1:                      readdata <= {30'b0, done, busy};
        4'd2, 4'd3, 4'd4, 4'd5:    readdata <= key_r[2'(address - 4'd2)];
        4'd6, 4'd7, 4'd8, 4'd9:    readdata <= data_r[2'(address - 4'd6)];
        4'd10, 4'd11, 4'd12, 4'd13: readdata <= res_r[2'(address - 4'd10)];
        default:                   readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: bus stimulus with a scoreboard of
// expected reads, plus a behavioural round-core model that checks the step
// sequence of every job against the job queued when it was started.
module tb_aes_round_sched;

  localparam int NR = 10;
  localparam int RW = 4;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          write = 1'b0;
  logic          chipselect = 1'b0;
  logic [3:0]    address = '0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic          core_load;
  logic          core_mode;
  logic [127:0]  core_key;
  logic [127:0]  core_block;
  logic          core_kexp;
  logic          core_req;
  logic [RW-1:0] core_round;
  logic          core_last;
  logic          core_ack = 1'b0;
  logic [127:0]  core_result = '0;

  aes_round_sched #(.NR(NR), .RW(RW)) dut (
    .clk(clk), .reset(reset), .write(write), .chipselect(chipselect),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq),
    .core_load(core_load), .core_mode(core_mode), .core_key(core_key),
    .core_block(core_block), .core_kexp(core_kexp), .core_req(core_req),
    .core_round(core_round), .core_last(core_last), .core_ack(core_ack),
    .core_result(core_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] k;
    logic [127:0] b;
    logic         m;
  } job_t;

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  logic spur = 1'b0;
  int done_seen = 0;
  int loads = 0;
  int starts = 0;

  job_t        ld_q [$];
  logic [31:0] rd_exp [$];
  string       rd_nm [$];

  task automatic chk_eq(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stand-in for the real AES transform: the FIPS-197 vector pairs map exactly,
  // anything else gets a cheap invertible-looking mix of key, block and mode.
  function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] b, input logic m);
    if (k == FIPS_KEY && b == FIPS_PT && !m) return FIPS_CT;
    if (k == FIPS_KEY && b == FIPS_CT && m) return FIPS_PT;
    return {b[95:0], b[127:96]} ^ k ^ {128{m}};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- bus driver (entered and left at posedge + 1) ----------
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1; chipselect = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    address = a; write = 1'b0; chipselect = 1'b1;
    @(posedge clk);
    rd_exp.push_back(e);
    rd_nm.push_back(nm);
    #1;
    chipselect = 1'b0;
  endtask

  task automatic write_regs(input logic [127:0] k, input logic [127:0] b);
    for (int i = 0; i < 4; i++) bus_wr(4'(2 + i), k[32*i +: 32]);
    for (int i = 0; i < 4; i++) bus_wr(4'(6 + i), b[32*i +: 32]);
  endtask

  // ---------------- read monitor ----------------
  initial begin : rd_monitor
    logic [31:0] e;
    string nm;
    forever begin
      @(negedge clk);
      while (rd_exp.size() > 0) begin
        e  = rd_exp.pop_front();
        nm = rd_nm.pop_front();
        chk_eq(nm, 128'(readdata), 128'(e));
      end
    end
  end

  // ---------------- core model + step monitor ----------------
  initial begin : core_model
    int   wait_cnt;
    int   step_i;
    bit   active;
    job_t cur;
    logic [127:0] lk;
    logic [127:0] lb;
    logic lm;
    int   stp_round [$];
    bit   stp_kexp [$];
    wait_cnt = 0; step_i = 0; active = 0;
    lk = '0; lb = '0; lm = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 0; core_ack = 1'b0; wait_cnt = 0;
      end else begin
        if (core_load) begin
          loads++;
          if (ld_q.size() == 0) begin
            chk_eq("unexpected_load", 128'(core_load), 128'(0));
          end else begin
            cur = ld_q.pop_front();
            chk_eq("load_key", core_key, cur.k);
            chk_eq("load_block", core_block, cur.b);
            chk_eq("load_mode", 128'(core_mode), 128'(cur.m));
            lk = core_key; lb = core_block; lm = core_mode;
            stp_round.delete(); stp_kexp.delete();
            if (cur.m) for (int r = 0; r < NR; r++) begin stp_round.push_back(r); stp_kexp.push_back(1'b1); end
            for (int r = 0; r <= NR; r++) begin stp_round.push_back(r); stp_kexp.push_back(1'b0); end
            step_i = 0; active = 1;
          end
        end
        if (core_req) begin
          if (!active) chk_eq("req_without_load", 128'(core_req), 128'(0));
          if (wait_cnt >= ack_delay) begin core_ack = 1'b1; wait_cnt = 0; end
          else begin core_ack = 1'b0; wait_cnt++; end
        end else begin
          if (active && !core_load) chk_eq("req_held", 128'(core_req), 128'(1));
          core_ack = spur; wait_cnt = 0;
        end
        if (core_req && core_ack && active) begin
          chk_eq("step_round", 128'(core_round), 128'(stp_round[step_i]));
          chk_eq("step_kexp", 128'(core_kexp), 128'(stp_kexp[step_i]));
          chk_eq("step_last", 128'(core_last), 128'(step_i == stp_round.size() - 1));
          if (step_i == stp_round.size() - 1) begin
            core_result = ref_aes(lk, lb, lm);
            active = 0;
            done_seen++;
          end else begin
            core_result = rand128();
          end
          step_i++;
        end
      end
    end
  end

  // ---------------- one complete job ----------------
  task automatic run(input logic [127:0] k, input logic [127:0] b, input logic m,
                     input logic ie, input int d, input bit sp, input string nm);
    int n;
    int n0;
    int lat;
    job_t j;
    logic [127:0] r;
    write_regs(k, b);
    ack_delay = d;
    j.k = k; j.b = b; j.m = m;
    ld_q.push_back(j);
    starts++;
    n0 = done_seen;
    lat = 2 + (NR + 1 + (m ? NR : 0)) * (d + 1);
    spur = sp;
    bus_wr(4'd0, {29'b0, ie, m, 1'b1});
    n = 0;
    while (n < 1000) begin
      @(posedge clk); #1; n++;
      spur = 1'b0;
      if (ie ? irq : (done_seen != n0)) break;
    end
    if (ie) chk_eq({nm, "_latency"}, 128'(n), 128'(lat));
    else begin
      chk_eq({nm, "_finished"}, 128'(done_seen - n0), 128'(1));
      @(posedge clk); #1;
    end
    r = ref_aes(k, b, m);
    chk_eq({nm, "_irq"}, 128'(irq), 128'(ie));
    bus_rd(4'd1, 32'h2, {nm, "_status"});
    bus_rd(4'd0, {29'b0, ie, m, 1'b0}, {nm, "_ctrl"});
    for (int i = 0; i < 4; i++) bus_rd(4'(10 + i), r[32*i +: 32], {nm, "_res"});
    if (ie) begin
      bus_wr(4'd1, 32'h2);
      chk_eq({nm, "_irq_clear"}, 128'(irq), 128'(0));
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [127:0] k;
    logic [127:0] b;
    int n;
    int n0;
    int l0;
    job_t j;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // reset state
    chk_eq("rst_req", 128'(core_req), 128'(0));
    chk_eq("rst_irq", 128'(irq), 128'(0));
    chk_eq("rst_load", 128'(core_load), 128'(0));
    chk_eq("rst_key", core_key, 128'(0));
    bus_rd(4'd0, 32'h0, "rst_ctrl");
    bus_rd(4'd1, 32'h0, "rst_status");
    bus_rd(4'd10, 32'h0, "rst_res0");

    // abort mid-ROUND at counter 5
    k = rand128(); b = rand128();
    write_regs(k, b);
    ack_delay = 3;
    j.k = k; j.b = b; j.m = 1'b0;
    ld_q.push_back(j);
    starts++;
    bus_wr(4'd0, 32'h5);
    n = 0;
    while (!(core_req && core_round == 4'd5) && n < 200) begin @(posedge clk); #1; n++; end
    chk_eq("reach_round5", 128'(core_round), 128'(5));
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_eq("abort_req", 128'(core_req), 128'(0));
    chk_eq("abort_irq", 128'(irq), 128'(0));
    chk_eq("abort_round", 128'(core_round), 128'(0));
    bus_rd(4'd0, 32'h0, "abort_ctrl");
    bus_rd(4'd1, 32'h0, "abort_status");
    bus_rd(4'd10, 32'h0, "abort_res0");
    bus_rd(4'd2, 32'h0, "abort_key0");

    // spurious ack in IDLE, unmapped addresses
    l0 = loads;
    spur = 1'b1;
    repeat (4) @(posedge clk);
    #1 spur = 1'b0;
    chk_eq("spur_round", 128'(core_round), 128'(0));
    chk_eq("spur_req", 128'(core_req), 128'(0));
    chk_eq("spur_loads", 128'(loads), 128'(l0));
    bus_rd(4'd0, 32'h0, "spur_ctrl");
    bus_wr(4'd14, 32'hffffffff);
    bus_rd(4'd14, 32'h0, "addr14");
    bus_rd(4'd15, 32'h0, "addr15");

    // FIPS-197 vectors; spurious ack held through the LOAD cycle of the first
    run(FIPS_KEY, FIPS_PT, 1'b0, 1'b1, 0, 1'b1, "fips_enc");
    run(FIPS_KEY, FIPS_CT, 1'b1, 1'b1, 3, 1'b0, "fips_dec");
    run(rand128(), rand128(), 1'b1, 1'b1, 0, 1'b0, "dec_fast");

    // busy protection
    k = rand128(); b = rand128();
    write_regs(k, b);
    ack_delay = 2;
    j.k = k; j.b = b; j.m = 1'b0;
    ld_q.push_back(j);
    starts++;
    n0 = done_seen;
    bus_wr(4'd0, 32'h1);
    bus_wr(4'd2, 32'hffffffff);
    bus_wr(4'd0, 32'h3);
    bus_rd(4'd1, 32'h1, "busy_status");
    bus_rd(4'd0, 32'h1, "busy_ctrl");
    bus_rd(4'd2, k[31:0], "busy_key0");
    bus_wr(4'd6, 32'h0);
    bus_rd(4'd6, b[31:0], "busy_data0");
    n = 0;
    while (done_seen == n0 && n < 1000) begin @(posedge clk); #1; n++; end
    chk_eq("busy_finished", 128'(done_seen - n0), 128'(1));
    @(posedge clk); #1;
    chk_eq("busy_irq_off", 128'(irq), 128'(0));
    bus_rd(4'd1, 32'h2, "busy_done");
    begin
      logic [127:0] r;
      r = ref_aes(k, b, 1'b0);
      for (int i = 0; i < 4; i++) bus_rd(4'(10 + i), r[32*i +: 32], "busy_res");
    end
    bus_wr(4'd2, 32'hffffffff);
    bus_rd(4'd2, 32'hffffffff, "idle_key0");

    // randomized jobs
    for (int t = 0; t < 6; t++) begin
      run(rand128(), rand128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    repeat (3) @(posedge clk);
    #1;
    chk_eq("load_count", 128'(loads), 128'(starts));
    chk_eq("jobs_drained", 128'(ld_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
